imm_gen: RTL and testbench



---
 rtl/imm_gen.sv | 85 ++++++++
 tb/tb_imm_gen.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/imm_gen.sv
// RV64I immediate generator: decodes the major opcode and sign-extends the
// instruction immediate, with a registered copy for the decode/execute boundary.
module imm_gen #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instruction,
    input  logic            valid_in,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      imm_type,
    output logic [XLEN-1:0] imm_q,
    output logic [2:0]      imm_type_q,
    output logic            valid_q
);

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } imm_fmt_e;

    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_IMM_32   = 7'b0011011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;

    logic            sign;
    imm_fmt_e        fmt_d;
    logic [XLEN-1:0] imm_d;

    assign sign = instruction[31];

    always_comb begin
        unique case (instruction[6:0])
            OP_LOAD, OP_IMM, OP_IMM_32, OP_JALR: fmt_d = FMT_I;
            OP_STORE:                             fmt_d = FMT_S;
            OP_BRANCH:                            fmt_d = FMT_B;
            OP_LUI, OP_AUIPC:                     fmt_d = FMT_U;
            OP_JAL:                               fmt_d = FMT_J;
            default:                              fmt_d = FMT_NONE;
        endcase
    end

    always_comb begin
        imm_d = '0;
        unique case (fmt_d)
            FMT_I: imm_d = {{(XLEN-12){sign}}, instruction[31:20]};
            FMT_S: imm_d = {{(XLEN-12){sign}}, instruction[31:25], instruction[11:7]};
            FMT_B: imm_d = {{(XLEN-12){sign}}, instruction[7], instruction[30:25],
                            instruction[11:8], 1'b0};
            FMT_U: imm_d = {{(XLEN-32){sign}}, instruction[31:12], 12'h000};
            FMT_J: imm_d = {{(XLEN-20){sign}}, instruction[19:12], instruction[20],
                            instruction[30:21], 1'b0};
            default: imm_d = '0;
        endcase
    end

    assign imm      = imm_d;
    assign imm_type = fmt_d;

    // Immediate and format only advance on valid instructions; valid tracks every edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imm_q      <= '0;
            imm_type_q <= FMT_NONE;
            valid_q    <= 1'b0;
        end else begin
            valid_q <= valid_in;
            if (valid_in) begin
                imm_q      <= imm_d;
                imm_type_q <= fmt_d;
            end
        end
    end

endmodule

// File: tb/tb_imm_gen.sv
// Self-checking bench for imm_gen: directed vectors, reset sequence and a
// randomized run compared against an arithmetic reference model.
module tb_imm_gen;

    logic        clk;
    logic        rst;
    logic [31:0] instruction;
    logic        valid_in;
    logic [63:0] imm;
    logic [2:0]  imm_type;
    logic [63:0] imm_q;
    logic [2:0]  imm_type_q;
    logic        valid_q;

    int unsigned total;
    int unsigned bad;

    imm_gen #(.XLEN(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .instruction(instruction),
        .valid_in   (valid_in),
        .imm        (imm),
        .imm_type   (imm_type),
        .imm_q      (imm_q),
        .imm_type_q (imm_type_q),
        .valid_q    (valid_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%016h expected=0x%016h", tag, got, exp);
        end
    endtask

    // Reference: field values weighted by their bit position, sign applied as a negative weight.
    function automatic longint ref_imm(input logic [31:0] ins, output logic [2:0] t);
        longint s;
        longint v;
        s = longint'(ins[31]);
        v = 0;
        case (ins[6:0])
            7'h03, 7'h13, 7'h1B, 7'h67: begin
                t = 3'd1;
                v = longint'(ins[30:20]) - s * 2048;
            end
            7'h23: begin
                t = 3'd2;
                v = longint'(ins[30:25]) * 32 + longint'(ins[11:7]) - s * 2048;
            end
            7'h63: begin
                t = 3'd3;
                v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
                    + longint'(ins[11:8]) * 2 - s * 4096;
            end
            7'h37, 7'h17: begin
                t = 3'd4;
                v = longint'(ins[30:12]) * 4096 - s * 64'sd2147483648;
            end
            7'h6F: begin
                t = 3'd5;
                v = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
                    + longint'(ins[30:21]) * 2 - s * 1048576;
            end
            default: begin
                t = 3'd0;
                v = 0;
            end
        endcase
        return v;
    endfunction

    logic [31:0] dir_ins  [7] = '{32'h00500093, 32'hFFF00093, 32'hFE000CE3, 32'hFE513E23,
                                  32'h800000B7, 32'h001000EF, 32'h00000033};
    logic [63:0] dir_imm  [7] = '{64'h0000000000000005, 64'hFFFFFFFFFFFFFFFF,
                                  64'hFFFFFFFFFFFFFFF8, 64'hFFFFFFFFFFFFFFFC,
                                  64'hFFFFFFFF80000000, 64'h0000000000000800, 64'h0};
    logic [2:0]  dir_type [7] = '{3'd1, 3'd1, 3'd3, 3'd2, 3'd4, 3'd5, 3'd0};
    logic [6:0]  ops      [10] = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h23, 7'h63,
                                   7'h37, 7'h17, 7'h6F, 7'h33};

    logic [63:0] exp_imm_q;
    logic [2:0]  exp_type_q;
    logic        exp_valid_q;
    logic [63:0] m_imm;
    logic [2:0]  m_type;

    initial begin
        total       = 0;
        bad         = 0;
        rst         = 1'b1;
        instruction = '0;
        valid_in    = 1'b0;
        #2;
        check_val("reset_imm_q", imm_q, 64'h0);
        check_val("reset_type_q", {61'h0, imm_type_q}, 64'h0);
        check_val("reset_valid_q", {63'h0, valid_q}, 64'h0);

        for (int i = 0; i < 7; i++) begin
            instruction = dir_ins[i];
            #1;
            check_val($sformatf("dir_imm_%0d", i), imm, dir_imm[i]);
            check_val($sformatf("dir_type_%0d", i), {61'h0, imm_type}, {61'h0, dir_type[i]});
        end

        // Load a non-zero value, then assert reset between edges.
        @(negedge clk);
        rst         = 1'b0;
        valid_in    = 1'b1;
        instruction = 32'hFFF00093;
        @(posedge clk);
        #1;
        check_val("preload_imm_q", imm_q, 64'hFFFFFFFFFFFFFFFF);
        #2;
        rst = 1'b1;
        #1;
        check_val("async_rst_imm_q", imm_q, 64'h0);
        check_val("async_rst_valid_q", {63'h0, valid_q}, 64'h0);
        check_val("async_rst_type_q", {61'h0, imm_type_q}, 64'h0);

        @(negedge clk);
        rst         = 1'b0;
        valid_in    = 1'b1;
        instruction = 32'h00500093;
        @(posedge clk);
        #1;
        check_val("post_rst_imm_q", imm_q, 64'h5);
        check_val("post_rst_valid_q", {63'h0, valid_q}, 64'h1);
        check_val("post_rst_type_q", {61'h0, imm_type_q}, 64'h1);

        @(negedge clk);
        valid_in    = 1'b0;
        instruction = 32'hFE000CE3;
        @(posedge clk);
        #1;
        check_val("hold_imm_q", imm_q, 64'h5);
        check_val("hold_valid_q", {63'h0, valid_q}, 64'h0);
        check_val("hold_type_q", {61'h0, imm_type_q}, 64'h1);

        exp_imm_q   = 64'h5;
        exp_type_q  = 3'd1;
        exp_valid_q = 1'b0;

        for (int n = 0; n < 400; n++) begin
            logic [31:0] r;
            @(negedge clk);
            r = $urandom;
            if ($urandom_range(0, 7) != 0)
                r[6:0] = ops[$urandom_range(0, 9)];
            instruction = r;
            valid_in    = ($urandom_range(0, 3) != 0);
            m_imm       = 64'(ref_imm(r, m_type));
            #1;
            check_val("rnd_imm", imm, m_imm);
            check_val("rnd_type", {61'h0, imm_type}, {61'h0, m_type});
            @(posedge clk);
            exp_valid_q = valid_in;
            if (valid_in) begin
                exp_imm_q  = m_imm;
                exp_type_q = m_type;
            end
            #1;
            check_val("rnd_imm_q", imm_q, exp_imm_q);
            check_val("rnd_type_q", {61'h0, imm_type_q}, {61'h0, exp_type_q});
            check_val("rnd_valid_q", {63'h0, valid_q}, {63'h0, exp_valid_q});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
